// File: rtl/sim_stop_pkg.sv
// Shared types for the simulation-termination controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sim_stop_pkg;

    localparam int STATUS_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_REPORT = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [STATUS_W-1:0] {
        STAT_NONE    = 2'd0,
        STAT_PASS    = 2'd1,
        STAT_FAIL    = 2'd2,
        STAT_TIMEOUT = 2'd3
    } status_t;

endpackage

// File: rtl/stop_timer.sv
// Saturating run-cycle counter with a latched limit and a timeout-hit compare.
// Latency: count is registered; hit is a decode of registered state plus enable.
// Backpressure: none; counts every enabled cycle, holds at all-ones.
// Ports: clear (load limit, zero count), enable (count this cycle),
//        limit_in (limit sampled on clear), count (cycles counted), hit (last cycle before limit).
module stop_timer #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] limit_in,
    output logic [TIMEOUT_W-1:0] count,
    output logic                 hit
);

    logic [TIMEOUT_W-1:0] limit_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            limit_q <= '0;
        end else if (clear) begin
            count   <= '0;
            limit_q <= limit_in;
        end else if (enable && (count != '1)) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    // Fires in the cycle whose increment makes count equal the limit, so the
    // count reads exactly the limit once the run has ended. A zero limit never fires.
    assign hit = enable && (limit_q != '0) && ((count + TIMEOUT_W'(1)) == limit_q);

endmodule

// File: rtl/sim_stop_controller.sv
// Collects tester done/fail events, enforces a cycle timeout, drains, then reports one status and stops.
// Latency: stop_valid DRAIN_CYCLES+1 cycles after the terminating event; stop one cycle after the handshake.
// Backpressure: status held on stop_valid until stop_ready; all outputs frozen once stopped.
// Ports: start/timeout_limit arm a run; src_done/src_fail are sticky per-source events;
//        busy, stop_valid/stop_ready, status, fail_mask, cycle_count, stop report the outcome.
module sim_stop_controller
    import sim_stop_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int TIMEOUT_W    = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_SRC-1:0]   src_done,
    input  logic [NUM_SRC-1:0]   src_fail,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic                 busy,
    output logic                 stop_valid,
    input  logic                 stop_ready,
    output logic [STATUS_W-1:0]  status,
    output logic [NUM_SRC-1:0]   fail_mask,
    output logic [TIMEOUT_W-1:0] cycle_count,
    output logic                 stop
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? DRAIN_W'(DRAIN_CYCLES - 1) : '0;

    state_t               state_q, state_d;
    status_t              status_q;
    logic [NUM_SRC-1:0]   done_seen;
    logic [NUM_SRC-1:0]   fail_q;
    logic [DRAIN_W-1:0]   drain_cnt;

    logic [NUM_SRC-1:0]   done_upd;
    logic [NUM_SRC-1:0]   fail_upd;
    logic                 timeout_hit;
    logic                 run_exit;
    status_t              exit_status;

    stop_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    ((state_q == ST_IDLE) && start),
        .enable   (state_q == ST_RUN),
        .limit_in (timeout_limit),
        .count    (cycle_count),
        .hit      (timeout_hit)
    );

    // Exit is judged on the masks including this cycle's events, so a fail or
    // last done arriving together with the timeout wins over it.
    always_comb begin
        done_upd    = done_seen | src_done;
        fail_upd    = fail_q | src_fail;
        run_exit    = (|fail_upd) || (&done_upd) || timeout_hit;
        exit_status = STAT_TIMEOUT;
        if (|fail_upd) begin
            exit_status = STAT_FAIL;
        end else if (&done_upd) begin
            exit_status = STAT_PASS;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_RUN;
            ST_RUN:    if (run_exit) state_d = (DRAIN_CYCLES == 0) ? ST_REPORT : ST_DRAIN;
            ST_DRAIN:  if (drain_cnt == '0) state_d = ST_REPORT;
            ST_REPORT: if (stop_ready) state_d = ST_HALT;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        stop_valid = 1'b0;
        stop       = 1'b0;
        case (state_q)
            ST_RUN, ST_DRAIN: busy       = 1'b1;
            ST_REPORT:        stop_valid = 1'b1;
            ST_HALT:          stop       = 1'b1;
            default:          ;
        endcase
    end

    // Sticky masks, final status and drain counter. Only IDLE (on start), RUN and
    // DRAIN may change them, which freezes everything during REPORT and HALT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_seen <= '0;
            fail_q    <= '0;
            status_q  <= STAT_NONE;
            drain_cnt <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        done_seen <= '0;
                        fail_q    <= '0;
                        status_q  <= STAT_NONE;
                    end
                end
                ST_RUN: begin
                    done_seen <= done_upd;
                    fail_q    <= fail_upd;
                    if (run_exit) begin
                        status_q  <= exit_status;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    fail_q <= fail_upd;
                    if (|src_fail) begin
                        status_q <= STAT_FAIL;
                    end
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign status    = status_q;
    assign fail_mask = fail_q;

endmodule

// File: tb/tb_sim_stop_controller.sv
module tb_sim_stop_controller;

    logic        clock;
    // Instance A: defaults (4 sources, 16-bit timer, drain 4)
    logic        a_reset, a_start, a_ready;
    logic [3:0]  a_done, a_fail;
    logic [15:0] a_limit;
    logic        a_busy, a_valid, a_stop;
    logic [1:0]  a_status;
    logic [3:0]  a_mask;
    logic [15:0] a_count;
    // Instance B: zero drain, 4-bit timer
    logic        b_reset, b_start, b_ready;
    logic [3:0]  b_done, b_fail;
    logic [3:0]  b_limit;
    logic        b_busy, b_valid, b_stop;
    logic [1:0]  b_status;
    logic [3:0]  b_mask;
    logic [3:0]  b_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sim_stop_controller dut_a (
        .clock(clock), .reset(a_reset), .start(a_start), .src_done(a_done),
        .src_fail(a_fail), .timeout_limit(a_limit), .busy(a_busy),
        .stop_valid(a_valid), .stop_ready(a_ready), .status(a_status),
        .fail_mask(a_mask), .cycle_count(a_count), .stop(a_stop)
    );

    sim_stop_controller #(.NUM_SRC(4), .TIMEOUT_W(4), .DRAIN_CYCLES(0)) dut_b (
        .clock(clock), .reset(b_reset), .start(b_start), .src_done(b_done),
        .src_fail(b_fail), .timeout_limit(b_limit), .busy(b_busy),
        .stop_valid(b_valid), .stop_ready(b_ready), .status(b_status),
        .fail_mask(b_mask), .cycle_count(b_count), .stop(b_stop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge: inputs set now are
    // sampled at the following edge; outputs read now belong to cycle cyc.
    task automatic step;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic a_outputs_reset(input string tag);
        chk({tag, "_busy"},  32'(a_busy),   32'd0);
        chk({tag, "_valid"}, 32'(a_valid),  32'd0);
        chk({tag, "_stop"},  32'(a_stop),   32'd0);
        chk({tag, "_stat"},  32'(a_status), 32'd0);
        chk({tag, "_mask"},  32'(a_mask),   32'd0);
        chk({tag, "_cnt"},   32'(a_count),  32'd0);
    endtask

    // Pulse reset low asynchronously mid-cycle, check outputs while it is low.
    task automatic a_async_reset(input string tag);
        a_reset = 1'b0;
        a_start = 1'b0; a_done = '0; a_fail = '0; a_ready = 1'b0;
        #1;
        a_outputs_reset(tag);
        #1;
        a_reset = 1'b1;
        cyc = 0;
    endtask

    function automatic logic [3:0] pass_done(input int c);
        case (c)
            5:       return 4'b0001;
            8:       return 4'b0010;
            9:       return 4'b0100;
            12:      return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    initial begin
        a_reset = 1'b0; a_start = 1'b0; a_ready = 1'b0; a_done = '0; a_fail = '0; a_limit = '0;
        b_reset = 1'b0; b_start = 1'b0; b_ready = 1'b0; b_done = '0; b_fail = '0; b_limit = '0;
        #12;
        a_outputs_reset("rst0");
        a_reset = 1'b1;
        cyc = 0;

        // ---------------- PASS run, drain 4 ----------------
        a_limit = 16'd100;
        step;                                   // cycle 1: ready high in IDLE
        a_ready = 1'b1;
        step;                                   // cycle 2
        chk("idle_ready_valid", 32'(a_valid), 32'd0);
        chk("idle_ready_stop",  32'(a_stop),  32'd0);
        chk("idle_busy",        32'(a_busy),  32'd0);
        a_ready = 1'b0;
        a_start = 1'b1;
        step;                                   // cycle 3
        chk("start_busy", 32'(a_busy), 32'd1);
        a_start = 1'b0;
        while (cyc < 16) begin
            a_done = pass_done(cyc);
            step;
        end
        a_done = '0;                            // cycle 16
        chk("pass_c16_valid", 32'(a_valid), 32'd0);
        chk("pass_c16_busy",  32'(a_busy),  32'd1);
        step;                                   // cycle 17
        chk("pass_c17_valid", 32'(a_valid),  32'd1);
        chk("pass_c17_busy",  32'(a_busy),   32'd0);
        chk("pass_status",    32'(a_status), 32'd1);
        chk("pass_count",     32'(a_count),  32'd10);
        chk("pass_mask",      32'(a_mask),   32'd0);
        a_ready = 1'b1;
        step;                                   // cycle 18
        a_ready = 1'b0;
        chk("pass_stop",     32'(a_stop),  32'd1);
        chk("pass_valid_lo", 32'(a_valid), 32'd0);
        a_start = 1'b1;                         // ignored in HALT
        a_fail  = 4'b1111;                      // ignored in HALT
        step;                                   // cycle 19
        a_start = 1'b0;
        a_fail  = '0;
        step;                                   // cycle 20
        chk("halt_stop_hold", 32'(a_stop),   32'd1);
        chk("halt_busy",      32'(a_busy),   32'd0);
        chk("halt_status",    32'(a_status), 32'd1);
        chk("halt_mask",      32'(a_mask),   32'd0);
        chk("halt_count",     32'(a_count),  32'd10);
        a_async_reset("rst_halt1");

        // ------- FAIL priority: fail + last done + timeout together -------
        a_limit = 16'd3;
        step;                                   // cycle 1
        a_start = 1'b1;
        step;                                   // cycle 2
        a_start = 1'b0;
        a_done  = 4'b1011;
        chk("fp_busy", 32'(a_busy),  32'd1);
        chk("fp_cnt0", 32'(a_count), 32'd0);
        step;                                   // cycle 3
        a_done  = '0;
        a_start = 1'b1;                         // ignored in RUN
        step;                                   // cycle 4
        a_start = 1'b0;
        chk("fp_start_in_run_cnt", 32'(a_count),  32'd2);
        chk("fp_status_none",      32'(a_status), 32'd0);
        a_done = 4'b0100;
        a_fail = 4'b0100;
        step;                                   // cycle 5
        a_done = '0;
        a_fail = '0;
        chk("fp_status", 32'(a_status), 32'd2);
        chk("fp_mask",   32'(a_mask),   32'd4);
        chk("fp_drain_busy", 32'(a_busy), 32'd1);
        step; step; step;                       // cycle 8
        chk("fp_c8_valid", 32'(a_valid), 32'd0);
        step;                                   // cycle 9: REPORT, ready stalled
        for (int i = 0; i < 3; i++) begin
            chk("fp_stall_valid",  32'(a_valid),  32'd1);
            chk("fp_stall_status", 32'(a_status), 32'd2);
            chk("fp_stall_stop",   32'(a_stop),   32'd0);
            step;
        end
        chk("fp_c12_valid", 32'(a_valid), 32'd1);
        a_ready = 1'b1;                         // cycle 12 handshake
        step;                                   // cycle 13
        a_ready = 1'b0;
        chk("fp_stop",     32'(a_stop),   32'd1);
        chk("fp_stop_vld", 32'(a_valid),  32'd0);
        chk("fp_mask_fin", 32'(a_mask),   32'd4);
        a_async_reset("rst_halt2");

        // ------- TIMEOUT then upgrade to FAIL during DRAIN -------
        a_limit = 16'd20;
        step;                                   // cycle 1
        a_start = 1'b1;
        step;                                   // cycle 2
        a_start = 1'b0;
        while (cyc < 21) step;                  // cycle 21
        chk("to_c21_cnt",    32'(a_count),  32'd19);
        chk("to_c21_status", 32'(a_status), 32'd0);
        step;                                   // cycle 22
        chk("to_status", 32'(a_status), 32'd3);
        chk("to_count",  32'(a_count),  32'd20);
        chk("to_busy",   32'(a_busy),   32'd1);
        step;                                   // cycle 23
        a_fail = 4'b0010;
        step;                                   // cycle 24
        a_fail = '0;
        chk("to_upgrade_status", 32'(a_status), 32'd2);
        chk("to_upgrade_mask",   32'(a_mask),   32'd2);
        chk("to_drain_busy",     32'(a_busy),   32'd1);
        a_async_reset("rst_drain");

        // ------- clean rerun: last done with timeout -> PASS, mask clear -------
        a_limit = 16'd2;
        step;                                   // cycle 1
        a_start = 1'b1;
        step;                                   // cycle 2
        a_start = 1'b0;
        step;                                   // cycle 3
        a_done = 4'b1111;
        step;                                   // cycle 4
        a_done = '0;
        chk("rr_status", 32'(a_status), 32'd1);
        chk("rr_mask",   32'(a_mask),   32'd0);
        chk("rr_count",  32'(a_count),  32'd2);

        // ------- Instance B: zero drain, timeout disabled, saturation -------
        b_reset = 1'b1;
        cyc = 0;
        b_limit = 4'd0;
        step;                                   // cycle 1
        b_start = 1'b1;
        step;                                   // cycle 2
        b_start = 1'b0;
        while (cyc < 16) step;                  // cycle 16
        chk("sat_c16_cnt", 32'(b_count), 32'd14);
        step;                                   // cycle 17
        chk("sat_c17_cnt", 32'(b_count), 32'd15);
        while (cyc < 20) step;                  // cycle 20
        b_done = 4'b0011;
        step;                                   // cycle 21
        b_done = '0;
        while (cyc < 25) step;                  // cycle 25
        chk("sat_c25_cnt",   32'(b_count), 32'd15);
        chk("sat_c25_busy",  32'(b_busy),  32'd1);
        chk("sat_c25_valid", 32'(b_valid), 32'd0);
        b_done = 4'b1100;
        step;                                   // cycle 26
        b_done = '0;
        chk("z_valid",  32'(b_valid),  32'd1);
        chk("z_status", 32'(b_status), 32'd1);
        chk("z_count",  32'(b_count),  32'd15);
        chk("z_busy",   32'(b_busy),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
